j_phase_decode: RTL

//  Downstream stage of the j_count Johnson counter: consumes its Q bus and decodes it to a phase index and one-hot phase.

---
 rtl/j_count_pkg.sv | 27 ++
 rtl/j_code_index.sv | 29 ++
 rtl/j_phase_decode.sv | 121 ++++++++++++
 3 files changed

// File: rtl/j_count_pkg.sv
// Shared definitions for the j_count Johnson counter and its downstream decoder:
// FSM state encodings, the Johnson successor function and the phase-width helper.
package j_count_pkg;

    typedef logic [1:0] jstate_t;

    localparam jstate_t UNLOCK = 2'd0;
    localparam jstate_t LOCKED = 2'd1;
    localparam jstate_t ERR    = 2'd2;

    // Widest code the helpers accept; callers zero-extend and truncate.
    localparam int JMAX = 32;

    // Shift toward the LSB with the inverted LSB entering at bit width-1.
    function automatic logic [JMAX-1:0] johnson_next(input logic [JMAX-1:0] code,
                                                     input int width);
        logic [JMAX-1:0] n;
        n            = code >> 1;
        n[width-1]   = ~code[0];
        return n;
    endfunction

    function automatic int ph_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/j_code_index.sv
// Combinational Johnson-code decoder: reports whether a code is a legal codeword
// and, if so, its position in the sequence starting from all-zeros.
module j_code_index
    import j_count_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PH_W  = ph_w(WIDTH)
) (
    input  logic [WIDTH-1:0] code_i,
    output logic             valid_o,
    output logic [PH_W-1:0]  index_o
);

    always_comb begin
        logic [WIDTH-1:0] c;
        valid_o = 1'b0;
        index_o = '0;
        c       = '0;
        // Walk the whole legal cycle; at most one step can match.
        for (int p = 0; p < 2 * WIDTH; p++) begin
            if (code_i == c) begin
                valid_o = 1'b1;
                index_o = PH_W'(p);
            end
            c = WIDTH'(johnson_next(JMAX'(c), WIDTH));
        end
    end

endmodule

// File: rtl/j_phase_decode.sv
// Decodes the j_count Q bus into phase/one-hot, tracks the Johnson sequence to
// lock onto it, flags illegal codes or jumps, and counts completed revolutions.
module j_phase_decode
    import j_count_pkg::*;
#(
    parameter int  WIDTH    = 4,
    parameter int  LOCK_CNT = 3,
    parameter int  CNT_W    = 8,
    parameter int  HOLD_OK  = 1,
    localparam int PH_W     = ph_w(WIDTH),
    localparam int NPH      = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] code_in,
    input  logic             err_clr,
    output logic [PH_W-1:0]  phase,
    output logic [NPH-1:0]   phase_onehot,
    output logic             code_valid,
    output logic             locked,
    output logic             code_err,
    output logic             rev_pulse,
    output logic [CNT_W-1:0] rev_count
);

    logic [WIDTH-1:0] code_r_q, code_prev_q;
    jstate_t          state_q, state_d;
    logic [3:0]       lock_cnt_q, lock_cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [NPH-1:0]   onehot_q, onehot_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             rev_q, rev_d;
    logic [CNT_W-1:0] rev_cnt_q, rev_cnt_d;

    logic             cur_valid;
    logic [PH_W-1:0]  cur_idx;
    logic             is_succ, is_hold, step_ok, rev_evt;

    j_code_index #(.WIDTH(WIDTH), .PH_W(PH_W)) u_idx (
        .code_i  (code_r_q),
        .valid_o (cur_valid),
        .index_o (cur_idx)
    );

    // An invalid previous code has an invalid successor, so is_succ implies both ends legal.
    assign is_succ = (code_r_q == WIDTH'(johnson_next(JMAX'(code_prev_q), WIDTH)));
    assign is_hold = (code_r_q == code_prev_q);
    assign step_ok = cur_valid && (is_succ || ((HOLD_OK != 0) && is_hold));

    always_ff @(posedge clk) begin
        if (reset) state_q <= UNLOCK;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCK: if (step_ok && is_succ && lock_cnt_q == 4'(LOCK_CNT - 1)) state_d = LOCKED;
            LOCKED: if (!step_ok) state_d = ERR;
            ERR:    if (step_ok && err_clr) state_d = UNLOCK;
            default: state_d = UNLOCK;
        endcase
    end

    always_comb begin
        lock_cnt_d = '0;
        if (state_q == UNLOCK && state_d == UNLOCK && step_ok)
            lock_cnt_d = is_succ ? lock_cnt_q + 4'd1 : lock_cnt_q;

        // The lock-completing step is in UNLOCK, so it never counts as a revolution.
        rev_evt = (state_q == LOCKED) && (state_d == LOCKED) && is_succ && (cur_idx == '0);

        rev_cnt_d = rev_cnt_q;
        if (state_q == LOCKED && state_d != LOCKED) rev_cnt_d = '0;
        else if (rev_evt)                           rev_cnt_d = rev_cnt_q + 1'b1;

        phase_d  = cur_valid ? cur_idx : '0;
        onehot_d = cur_valid ? (NPH'(1) << cur_idx) : '0;
        valid_d  = cur_valid;
        locked_d = (state_d == LOCKED);
        err_d    = (state_d == ERR);
        rev_d    = rev_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_r_q    <= '0;
            code_prev_q <= '0;
            lock_cnt_q  <= '0;
            phase_q     <= '0;
            onehot_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            rev_q       <= 1'b0;
            rev_cnt_q   <= '0;
        end else begin
            code_r_q    <= code_in;
            code_prev_q <= code_r_q;
            lock_cnt_q  <= lock_cnt_d;
            phase_q     <= phase_d;
            onehot_q    <= onehot_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            rev_q       <= rev_d;
            rev_cnt_q   <= rev_cnt_d;
        end
    end

    assign phase        = phase_q;
    assign phase_onehot = onehot_q;
    assign code_valid   = valid_q;
    assign locked       = locked_q;
    assign code_err     = err_q;
    assign rev_pulse    = rev_q;
    assign rev_count    = rev_cnt_q;

endmodule
